// File: rtl/div_share_sched_pkg.sv
// Shared types and constants for the two-pipe shared iterative divider.
package div_share_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  typedef struct packed {
    logic [31:0] opd1;
    logic [31:0] opd2;
    logic        is_mod;
    logic        is_unsigned;
  } div_req_t;

  localparam logic [31:0] DIV_BY_ZERO_RES = 32'hFFFF_FFFF;
  localparam logic [4:0]  LAST_STEP       = 5'd31;

  // Magnitude of a signed operand; 0x80000000 maps to itself as an unsigned value.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [1:0] pipe_oh(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/div_share_sched_if.sv
// Request/response bundle between the two execute pipes and the shared divider.
interface div_share_sched_if;
  logic             flush_i;
  logic [1:0]       req_valid_i;
  logic [1:0]       req_ready_o;
  logic [1:0][31:0] req_opd1_i;
  logic [1:0][31:0] req_opd2_i;
  logic [1:0]       req_is_mod_i;
  logic [1:0]       req_unsigned_i;
  logic [1:0]       resp_valid_o;
  logic [1:0]       resp_ready_i;
  logic [31:0]      resp_data_o;
  logic             busy_o;

  modport slave (
    input  flush_i, req_valid_i, req_opd1_i, req_opd2_i, req_is_mod_i, req_unsigned_i,
           resp_ready_i,
    output req_ready_o, resp_valid_o, resp_data_o, busy_o
  );

  modport master (
    output flush_i, req_valid_i, req_opd1_i, req_opd2_i, req_is_mod_i, req_unsigned_i,
           resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_data_o, busy_o
  );
endinterface

// File: rtl/div_share_sched_div_iter_core.sv
// Restoring radix-2 divider datapath: one quotient bit per step, MSB first,
// with sign fix-up folded into the last step so the result registers are final.
module div_iter_core
  import div_share_sched_pkg::*;
#(
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] opd1_i,
  input  logic [31:0] opd2_i,
  input  logic        unsigned_i,
  input  logic        step_i,
  input  logic [4:0]  cnt_i,
  output logic [31:0] quot_o,
  output logic [31:0] rem_o
);

  logic [31:0] dvs_q, quo_q, rem_q, quot_q, remr_q;
  logic        neg_quot_q, neg_rem_q, dz_q;

  logic        dz_in;
  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] rem_nx, quo_nx;
  logic        last;

  assign dz_in  = (opd2_i == 32'd0);
  assign rem_sh = {rem_q, quo_q[31]};
  // rem_sh[32] set means the shifted remainder already exceeds any 32-bit divisor
  assign ge     = rem_sh[32] | (rem_sh[31:0] >= dvs_q);
  assign rem_nx = ge ? (rem_sh[31:0] - dvs_q) : rem_sh[31:0];
  assign quo_nx = {quo_q[30:0], ge};
  assign last   = step_i & (cnt_i == 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvs_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      remr_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
    end else if (start_i) begin
      dvs_q      <= abs32(opd2_i, ~unsigned_i);
      quo_q      <= abs32(opd1_i, ~unsigned_i);
      rem_q      <= '0;
      neg_quot_q <= ~unsigned_i & (opd1_i[31] ^ opd2_i[31]);
      neg_rem_q  <= ~unsigned_i & opd1_i[31];
      dz_q       <= dz_in;
      if (ZERO_BYPASS && dz_in) begin
        quot_q <= DIV_BY_ZERO_RES;
        remr_q <= DIV_BY_ZERO_RES;
      end
    end else if (step_i) begin
      quo_q <= quo_nx;
      rem_q <= rem_nx;
      if (last) begin
        quot_q <= dz_q ? DIV_BY_ZERO_RES : (neg_quot_q ? (~quo_nx + 32'd1) : quo_nx);
        remr_q <= dz_q ? DIV_BY_ZERO_RES : (neg_rem_q  ? (~rem_nx + 32'd1) : rem_nx);
      end
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = remr_q;

endmodule

// File: rtl/div_share_sched.sv
// Shared DIV/MOD unit for the two execute pipes: round-robin arbiter, scheduler FSM
// and one iterative divide in flight at a time.
//   state | meaning
//   IDLE  | free; arbiter may grant one pipe
//   CALC  | 32 divide steps, counter 31 -> 0
//   DONE  | result held for the owning pipe until it accepts
module div_share_sched
  import div_share_sched_pkg::*;
#(
  parameter bit ZERO_BYPASS = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  div_share_sched_if.slave bus
);

  div_state_t state_q;
  logic       ptr_q, owner_q, is_mod_q;
  logic [4:0] cnt_q;
  logic [1:0] resp_valid_q;

  logic [1:0]  grant, ready;
  logic        acc, acc_id, dz, step, hs;
  div_req_t    req_sel;
  logic [31:0] quot, rem;

  always_comb begin
    grant = bus.req_valid_i;
    if (&bus.req_valid_i) grant = ptr_q ? 2'b10 : 2'b01;
  end

  // Gated by rst_n so no grant is offered while the block is held in reset.
  assign ready  = grant & {2{(state_q == IDLE) & ~bus.flush_i & rst_n}};
  assign acc    = |ready;
  assign acc_id = ready[1];

  always_comb begin
    req_sel.opd1        = bus.req_opd1_i[acc_id];
    req_sel.opd2        = bus.req_opd2_i[acc_id];
    req_sel.is_mod      = bus.req_is_mod_i[acc_id];
    req_sel.is_unsigned = bus.req_unsigned_i[acc_id];
  end

  assign dz   = (req_sel.opd2 == 32'd0);
  assign step = (state_q == CALC) & ~bus.flush_i;
  assign hs   = |(resp_valid_q & bus.resp_ready_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      owner_q      <= 1'b0;
      is_mod_q     <= 1'b0;
      cnt_q        <= '0;
      resp_valid_q <= '0;
    end else if (bus.flush_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc) begin
            owner_q  <= acc_id;
            is_mod_q <= req_sel.is_mod;
            ptr_q    <= ~acc_id;
            if (dz && ZERO_BYPASS) begin
              state_q      <= DONE;
              resp_valid_q <= pipe_oh(acc_id);
            end else begin
              state_q <= CALC;
              cnt_q   <= LAST_STEP;
            end
          end
        end
        CALC: begin
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            state_q      <= DONE;
            cnt_q        <= '0;
            resp_valid_q <= pipe_oh(owner_q);
          end
        end
        DONE: begin
          if (hs) begin
            state_q      <= IDLE;
            resp_valid_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  div_iter_core #(.ZERO_BYPASS(ZERO_BYPASS)) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (acc),
    .opd1_i     (req_sel.opd1),
    .opd2_i     (req_sel.opd2),
    .unsigned_i (req_sel.is_unsigned),
    .step_i     (step),
    .cnt_i      (cnt_q),
    .quot_o     (quot),
    .rem_o      (rem)
  );

  assign bus.req_ready_o  = ready;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_data_o  = is_mod_q ? rem : quot;
  assign bus.busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_div_share_sched.sv
// Directed bench for div_share_sched: vector table of single operations plus
// hand-written sequences for arbitration, back-pressure, flush and reset.
module tb_div_share_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             sel = 1'b0;
  logic             flush = 1'b0;
  logic [1:0]       valid = '0;
  logic [1:0][31:0] opd1 = '0;
  logic [1:0][31:0] opd2 = '0;
  logic [1:0]       is_mod = '0;
  logic [1:0]       uns = '0;
  logic [1:0]       rsp_rdy = '0;

  div_share_sched_if if0 ();
  div_share_sched_if if1 ();

  assign if0.flush_i        = flush;
  assign if0.req_valid_i    = sel ? 2'b00 : valid;
  assign if0.req_opd1_i     = opd1;
  assign if0.req_opd2_i     = opd2;
  assign if0.req_is_mod_i   = is_mod;
  assign if0.req_unsigned_i = uns;
  assign if0.resp_ready_i   = sel ? 2'b00 : rsp_rdy;

  assign if1.flush_i        = flush;
  assign if1.req_valid_i    = sel ? valid : 2'b00;
  assign if1.req_opd1_i     = opd1;
  assign if1.req_opd2_i     = opd2;
  assign if1.req_is_mod_i   = is_mod;
  assign if1.req_unsigned_i = uns;
  assign if1.resp_ready_i   = sel ? rsp_rdy : 2'b00;

  div_share_sched #(.ZERO_BYPASS(1'b1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  div_share_sched #(.ZERO_BYPASS(1'b0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  logic [1:0]  rdy, rv;
  logic [31:0] data;
  logic        busy;
  assign rdy  = sel ? if1.req_ready_o  : if0.req_ready_o;
  assign rv   = sel ? if1.resp_valid_o : if0.resp_valid_o;
  assign data = sel ? if1.resp_data_o  : if0.resp_data_o;
  assign busy = sel ? if1.busy_o       : if0.busy_o;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  typedef struct {
    logic        sel;
    logic        pipe;
    logic [31:0] a;
    logic [31:0] b;
    logic        is_mod;
    logic        uns;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[18];

  task automatic run_op(input vec_t v, input int idx);
    int n, k;
    @(posedge clk); #1;
    sel = v.sel;
    valid = v.pipe ? 2'b10 : 2'b01;
    opd1[v.pipe] = v.a;
    opd2[v.pipe] = v.b;
    is_mod[v.pipe] = v.is_mod;
    uns[v.pipe] = v.uns;
    n = 0;
    @(negedge clk);
    while (rdy[v.pipe] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin timeout($sformatf("v%0d_ready", idx)); valid = '0; return; end
    @(posedge clk); #1;
    // operands scrambled after accept must not affect the result
    valid = '0;
    opd1[v.pipe] = 32'h1234_5678;
    opd2[v.pipe] = 32'h0;
    is_mod[v.pipe] = ~v.is_mod;
    uns[v.pipe] = ~v.uns;
    k = 0;
    do begin @(negedge clk); k++; end while (rv == 2'b00 && k < 40);
    chk($sformatf("v%0d_latency", idx), k, v.lat);
    chk($sformatf("v%0d_resp_valid", idx), {30'd0, rv}, {30'd0, v.pipe ? 2'b10 : 2'b01});
    chk($sformatf("v%0d_data", idx), data, v.exp);
    @(posedge clk); #1;
    rsp_rdy = v.pipe ? 2'b10 : 2'b01;
    @(posedge clk); #1;
    rsp_rdy = '0;
    @(negedge clk);
    chk($sformatf("v%0d_idle_after", idx), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n, k;
    logic seen;

    vt[0]  = '{1'b0, 1'b0, 32'd7,          32'd2,          1'b0, 1'b0, 32'd3,          33};
    vt[1]  = '{1'b0, 1'b1, 32'hFFFF_FFF9,  32'd2,          1'b1, 1'b0, 32'hFFFF_FFFF,  33};
    vt[2]  = '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'd2,          1'b0, 1'b1, 32'h7FFF_FFFF,  33};
    vt[3]  = '{1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b0, 32'h8000_0000,  33};
    vt[4]  = '{1'b0, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0, 32'h0,          33};
    vt[5]  = '{1'b0, 1'b0, 32'd5,          32'd0,          1'b0, 1'b0, 32'hFFFF_FFFF,  1};
    vt[6]  = '{1'b0, 1'b1, 32'd5,          32'd0,          1'b1, 1'b1, 32'hFFFF_FFFF,  1};
    vt[7]  = '{1'b0, 1'b0, 32'hFFFF_FFFB,  32'd0,          1'b0, 1'b0, 32'hFFFF_FFFF,  1};
    vt[8]  = '{1'b0, 1'b1, 32'hFFFF_FF9C,  32'd7,          1'b0, 1'b0, 32'hFFFF_FFF2,  33};
    vt[9]  = '{1'b0, 1'b0, 32'hFFFF_FF9C,  32'd7,          1'b1, 1'b0, 32'hFFFF_FFFE,  33};
    vt[10] = '{1'b0, 1'b1, 32'd100,        32'hFFFF_FFF9,  1'b1, 1'b0, 32'd2,          33};
    vt[11] = '{1'b0, 1'b0, 32'h8000_0000,  32'd3,          1'b0, 1'b1, 32'h2AAA_AAAA,  33};
    vt[12] = '{1'b0, 1'b1, 32'h8000_0000,  32'd3,          1'b1, 1'b1, 32'd2,          33};
    vt[13] = '{1'b0, 1'b0, 32'h8000_0000,  32'd2,          1'b0, 1'b0, 32'hC000_0000,  33};
    vt[14] = '{1'b0, 1'b0, 32'd100,        32'hFFFF_FFF9,  1'b0, 1'b1, 32'd0,          33};
    vt[15] = '{1'b1, 1'b0, 32'd5,          32'd0,          1'b0, 1'b0, 32'hFFFF_FFFF,  33};
    vt[16] = '{1'b1, 1'b1, 32'hFFFF_FFFB,  32'd0,          1'b1, 1'b0, 32'hFFFF_FFFF,  33};
    vt[17] = '{1'b1, 1'b0, 32'd7,          32'd2,          1'b0, 1'b0, 32'd3,          33};

    // reset state, with both pipes requesting
    valid = 2'b11;
    repeat (3) @(negedge clk);
    chk("rst_ready", {30'd0, rdy}, 32'd0);
    chk("rst_resp_valid", {30'd0, rv}, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // both pipes requesting continuously: grants alternate starting at pipe 0
    @(posedge clk); #1;
    sel = 1'b0;
    opd1[0] = 32'd20; opd2[0] = 32'd4;
    opd1[1] = 32'd21; opd2[1] = 32'd3;
    is_mod = '0; uns = '0;
    rsp_rdy = 2'b11;
    valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      @(negedge clk);
      while (rdy == 2'b00 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) timeout($sformatf("rr%0d_ready", i));
      chk($sformatf("rr%0d_grant", i), {30'd0, rdy}, {30'd0, i[0] ? 2'b10 : 2'b01});
      @(posedge clk);
      k = 0;
      do begin @(negedge clk); k++; end while (rv == 2'b00 && k < 40);
      chk($sformatf("rr%0d_resp_valid", i), {30'd0, rv}, {30'd0, i[0] ? 2'b10 : 2'b01});
      chk($sformatf("rr%0d_data", i), data, i[0] ? 32'd7 : 32'd5);
      chk($sformatf("rr%0d_other_pending", i), {30'd0, rdy}, 32'd0);
    end
    @(posedge clk); #1;
    valid = '0;
    rsp_rdy = '0;

    for (int i = 0; i < 18; i++) run_op(vt[i], i);
    sel = 1'b0;

    // back-pressure in DONE while the other pipe waits
    @(posedge clk); #1;
    opd1[1] = 32'd9; opd2[1] = 32'd3; is_mod[1] = 1'b0; uns[1] = 1'b0;
    opd1[0] = 32'd50; opd2[0] = 32'd5; is_mod[0] = 1'b0; uns[0] = 1'b0;
    valid = 2'b10;
    n = 0;
    @(negedge clk);
    while (rdy[1] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("bp_ready");
    @(posedge clk); #1;
    valid = 2'b01;
    k = 0;
    do begin @(negedge clk); k++; end while (rv == 2'b00 && k < 40);
    chk("bp_latency", k, 33);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_resp_valid", i), {30'd0, rv}, 32'd2);
      chk($sformatf("bp%0d_data", i), data, 32'd3);
      chk($sformatf("bp%0d_ready", i), {30'd0, rdy}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_rdy = 2'b10;
    @(posedge clk); #1;
    rsp_rdy = '0;
    @(negedge clk);
    chk("bp_idle_after", {31'd0, busy}, 32'd0);
    chk("bp_next_grant", {30'd0, rdy}, 32'd1);

    // pipe 0 accepted on the next edge; flush it in CALC cycle 15
    @(posedge clk); #1;
    valid = '0;
    repeat (14) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = seen | (|rv) | busy;
    end
    chk("flush_no_resp", {31'd0, seen}, 32'd0);

    // no accept during a flush cycle
    @(posedge clk); #1;
    valid = 2'b01;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", {30'd0, rdy}, 32'd0);
    @(posedge clk); #1;
    valid = '0;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_no_accept", {31'd0, busy}, 32'd0);

    // reset pulse mid-CALC on a pipe-0 op (pointer then points at pipe 1)
    @(posedge clk); #1;
    valid = 2'b01;
    n = 0;
    @(negedge clk);
    while (rdy[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) timeout("rst_mid_ready");
    @(posedge clk); #1;
    valid = 2'b11;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_resp_valid", {30'd0, rv}, 32'd0);
    chk("rst_mid_data", data, 32'd0);
    chk("rst_mid_ready", {30'd0, rdy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ptr_grant", {30'd0, rdy}, 32'd1);
    @(posedge clk); #1;
    valid = '0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_vec);
    $fatal(1);
  end

endmodule
